// File: rtl/cmp_rr_arbiter.sv
// Round-robin arbiter sharing one registered magnitude comparator among N_REQ requesters.
// Optional feature macro: CMP_SIGNED_EN adds a per-requester sgn input for two's-complement compares.
module cmp_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   a_in,
    input  logic [N_REQ*WIDTH-1:0]   b_in,
`ifdef CMP_SIGNED_EN
    input  logic [N_REQ-1:0]         sgn,
`endif
    output logic [N_REQ-1:0]         gnt,
    output logic                     busy,
    output logic                     rsp_valid,
    output logic [IDW-1:0]           rsp_id,
    output logic                     rsp_eq,
    output logic                     rsp_gt,
    output logic                     rsp_lt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t                 state_r;
    logic [IDW-1:0]         ptr_r;
    logic [IDW-1:0]         win_r;
    logic [WIDTH-1:0]       a_r;
    logic [WIDTH-1:0]       b_r;
    logic [N_REQ-1:0]       gnt_r;
    logic                   busy_r;
    logic                   rsp_valid_r;
    logic [IDW-1:0]         rsp_id_r;
    logic                   rsp_eq_r;
    logic                   rsp_gt_r;
    logic                   rsp_lt_r;
`ifdef CMP_SIGNED_EN
    logic                   sgn_r;
`endif

    logic                   found_s;
    logic [IDW-1:0]         win_s;
    logic [IDW:0]           scan_s;
    logic [WIDTH-1:0]       a_sel_s;
    logic [WIDTH-1:0]       b_sel_s;
    logic [IDW-1:0]         ptr_next_s;
    logic [2:0]             flags_s;

    // Flags returned as {eq, gt, lt}; signed compare is done by flipping the sign bits.
    function automatic logic [2:0] cmp_flags(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic             is_signed);
        logic [WIDTH-1:0] ax;
        logic [WIDTH-1:0] bx;
        ax = a;
        bx = b;
        if (is_signed) begin
            ax[WIDTH-1] = ~a[WIDTH-1];
            bx[WIDTH-1] = ~b[WIDTH-1];
        end else begin
            ax = a;
            bx = b;
        end
        if (ax == bx) begin
            return 3'b100;
        end else if (ax > bx) begin
            return 3'b010;
        end else begin
            return 3'b001;
        end
    endfunction

    // Pick the first asserted request scanning upward from the round-robin pointer.
    always_comb begin
        found_s = 1'b0;
        win_s   = {IDW{1'b0}};
        scan_s  = {(IDW+1){1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            scan_s = {1'b0, ptr_r} + (IDW+1)'(i);
            if (scan_s >= (IDW+1)'(N_REQ)) begin
                scan_s = scan_s - (IDW+1)'(N_REQ);
            end else begin
                scan_s = scan_s;
            end
            if (!found_s && req[scan_s[IDW-1:0]]) begin
                found_s = 1'b1;
                win_s   = scan_s[IDW-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Operand mux for the winner, pointer advance and compare of the latched operands.
    always_comb begin
        a_sel_s    = a_in[int'(win_s)*WIDTH +: WIDTH];
        b_sel_s    = b_in[int'(win_s)*WIDTH +: WIDTH];
        if (win_r == IDW'(N_REQ-1)) begin
            ptr_next_s = {IDW{1'b0}};
        end else begin
            ptr_next_s = win_r + IDW'(1);
        end
`ifdef CMP_SIGNED_EN
        flags_s    = cmp_flags(a_r, b_r, sgn_r);
`else
        flags_s    = cmp_flags(a_r, b_r, 1'b0);
`endif
    end

    // Arbitration FSM: grant and latch, then compare and strobe, then one idle cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            ptr_r       <= {IDW{1'b0}};
            win_r       <= {IDW{1'b0}};
            a_r         <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            gnt_r       <= {N_REQ{1'b0}};
            busy_r      <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= {IDW{1'b0}};
            rsp_eq_r    <= 1'b0;
            rsp_gt_r    <= 1'b0;
            rsp_lt_r    <= 1'b0;
`ifdef CMP_SIGNED_EN
            sgn_r       <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    rsp_valid_r <= 1'b0;
                    if (found_s) begin
                        state_r <= ST_GRANT;
                        gnt_r   <= {{(N_REQ-1){1'b0}}, 1'b1} << win_s;
                        busy_r  <= 1'b1;
                        win_r   <= win_s;
                        a_r     <= a_sel_s;
                        b_r     <= b_sel_s;
`ifdef CMP_SIGNED_EN
                        sgn_r   <= sgn[win_s];
`endif
                    end else begin
                        state_r <= ST_IDLE;
                        gnt_r   <= {N_REQ{1'b0}};
                        busy_r  <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    state_r     <= ST_RESP;
                    gnt_r       <= {N_REQ{1'b0}};
                    busy_r      <= 1'b1;
                    rsp_valid_r <= 1'b1;
                    rsp_id_r    <= win_r;
                    rsp_eq_r    <= flags_s[2];
                    rsp_gt_r    <= flags_s[1];
                    rsp_lt_r    <= flags_s[0];
                    ptr_r       <= ptr_next_s;
                end
                ST_RESP: begin
                    state_r     <= ST_IDLE;
                    gnt_r       <= {N_REQ{1'b0}};
                    busy_r      <= 1'b0;
                    rsp_valid_r <= 1'b0;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    gnt_r       <= {N_REQ{1'b0}};
                    busy_r      <= 1'b0;
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign gnt       = gnt_r;
    assign busy      = busy_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = rsp_id_r;
    assign rsp_eq    = rsp_eq_r;
    assign rsp_gt    = rsp_gt_r;
    assign rsp_lt    = rsp_lt_r;

endmodule
